// File: rtl/loader_pkg.sv
// Shared types and defaults for the framed serial program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HUNT,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000000;
  localparam int unsigned TMO_W_DEF          = $clog2(TIMEOUT_CYCLES_DEF + 1);

  // Counter width able to hold the value 'cycles' itself.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/byte_strobe.sv
// Registered rising-edge detector on the receiver's data-ready level.
module byte_strobe (
  input  logic sysclk,
  input  logic sysrst,
  input  logic byte_valid,
  output logic strobe_c
);

  logic prev_valid;

  // Resets high so a level already present at reset is not taken as a byte.
  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) prev_valid <= 1'b1;
    else         prev_valid <= byte_valid;
  end

  assign strobe_c = byte_valid & ~prev_valid;

endmodule

// File: rtl/uart_loader.sv
// Framed serial loader: sync, length, data words, checksum -> 16-bit memory writes.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  sysclk,
  input  logic                  sysrst,
  input  logic                  load_en,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
);

  localparam int unsigned TMO_W = tmo_width(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic [7:0]              hi_q, hi_d;
  logic [7:0]              sum_q, sum_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d, len_n;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    we_d, busy_d, done_d, error_d;
  logic [ADDR_WIDTH-1:0]   addr_d, ww_d;
  logic [WORD_WIDTH-1:0]   data_d;
  logic                    strobe_c;
  logic                    in_frame_c;

  byte_strobe u_strobe (
    .sysclk     (sysclk),
    .sysrst     (sysrst),
    .byte_valid (byte_valid),
    .strobe_c   (strobe_c)
  );

  assign in_frame_c = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA_HI) ||
                      (state_q == DATA_LO) || (state_q == CHECK);

  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      sum_q         <= '0;
      len_q         <= '0;
      tmo_q         <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      sum_q         <= sum_d;
      len_q         <= len_d;
      tmo_q         <= tmo_d;
      mem_we        <= we_d;
      mem_addr      <= addr_d;
      mem_data      <= data_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      words_written <= ww_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    len_d   = len_q;
    len_n   = len_q | ADDR_WIDTH'(byte_in);
    we_d    = 1'b0;
    addr_d  = mem_addr;
    data_d  = mem_data;
    ww_d    = words_written;
    // Cycles since the last accepted byte, only while a frame is open.
    tmo_d   = (in_frame_c && !strobe_c) ? tmo_q + TMO_W'(1) : '0;

    unique case (state_q)
      IDLE: state_d = HUNT;
      HUNT, DONE, ERROR: begin
        if (strobe_c && byte_in == SYNC_BYTE) begin
          state_d = LEN_HI;
          sum_d   = '0;
          ww_d    = '0;
        end
      end
      LEN_HI: begin
        if (strobe_c) begin
          len_d   = ADDR_WIDTH'({byte_in, 8'h00});
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (strobe_c) begin
          len_d = len_n;
          if (32'(len_n) > MAX_WORDS) state_d = ERROR;
          else if (len_n == '0)       state_d = CHECK;
          else                        state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (strobe_c) begin
          hi_d    = byte_in;
          sum_d   = sum_q + byte_in;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (strobe_c) begin
          we_d    = 1'b1;
          addr_d  = words_written;
          data_d  = WORD_WIDTH'({hi_q, byte_in});
          ww_d    = words_written + ADDR_WIDTH'(1);
          sum_d   = sum_q + byte_in;
          state_d = (words_written + ADDR_WIDTH'(1) == len_q) ? CHECK : DATA_HI;
        end
      end
      CHECK: begin
        if (strobe_c) state_d = (byte_in == sum_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving in the same cycle as the limit still counts as on time.
    if (in_frame_c && !strobe_c && tmo_q == TMO_W'(TIMEOUT_CYCLES)) state_d = ERROR;

    // Leaving load mode wins over everything, including a pending write.
    if (!load_en) begin
      state_d = IDLE;
      we_d    = 1'b0;
      ww_d    = '0;
    end

    busy_d  = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA_HI) ||
              (state_d == DATA_LO) || (state_d == CHECK);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: frames, hunt, bad checksum, length, timeout, abort, reset.
module tb_uart_loader;
  import loader_pkg::*;

  localparam int unsigned TMO = 200;

  logic        sysclk = 1'b0;
  logic        sysrst;
  logic        load_en;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_base;

  uart_loader #(
    .WORD_WIDTH     (16),
    .ADDR_WIDTH     (16),
    .MAX_WORDS      (1024),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sysclk        (sysclk),
    .sysrst        (sysrst),
    .load_en       (load_en),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 sysclk = ~sysclk;

  // Count every cycle mem_we is high; a stuck strobe shows up as extra writes.
  always @(posedge sysclk) if (mem_we === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the accept edge, so the byte's effect is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge sysclk);
    @(negedge sysclk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge sysclk);
    byte_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    sysrst     = 1'b0;
    load_en    = 1'b1;
    byte_in    = 8'hA5;
    byte_valid = 1'b1;
    idle(3);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_flags", {29'd0, busy, done, error}, 0);
    chk("rst_ww", 32'(words_written), 0);
    sysrst = 1'b1;
    idle(4);
    chk("held_valid_ignored", 32'(busy), 0);
    chk("hunt_state", 32'(dut.state_q), 32'(HUNT));
    byte_valid = 1'b0;

    // Normal two-word frame; checksum 12+34+AB+CD = 0x1BE -> BE.
    wr_base = wr_cnt;
    send_byte(8'hA5);
    chk("f1_busy", 32'(busy), 1);
    send_bytes('{8'h00, 8'h02, 8'h12, 8'h34});
    chk("f1_w0", {15'd0, mem_we, mem_addr}, 32'h0001_0000);
    chk("f1_d0", 32'(mem_data), 32'h1234);
    idle(1);
    chk("f1_we_pulse", 32'(mem_we), 0);
    send_bytes('{8'hAB, 8'hCD});
    chk("f1_w1", {15'd0, mem_we, mem_addr}, 32'h0001_0001);
    chk("f1_d1", 32'(mem_data), 32'hABCD);
    send_byte(8'hBE);
    chk("f1_flags", {29'd0, busy, done, error}, 32'b010);
    idle(2);
    chk("f1_ww", 32'(words_written), 2);
    chk("f1_wr_cnt", 32'(wr_cnt - wr_base), 2);

    // Sync hunt from DONE: junk ignored, A5 restarts.
    wr_base = wr_cnt;
    send_bytes('{8'h00, 8'hFF});
    chk("hunt_done_held", {30'd0, done, busy}, 32'b10);
    send_byte(8'hA5);
    chk("hunt_restart", {29'd0, busy, done, error}, 32'b100);
    chk("hunt_ww_clr", 32'(words_written), 0);
    send_bytes('{8'h00, 8'h01, 8'hBE, 8'hEF});
    chk("hunt_w0", {15'd0, mem_we, mem_addr}, 32'h0001_0000);
    chk("hunt_d0", 32'(mem_data), 32'hBEEF);
    send_byte(8'hAD);
    chk("hunt_flags", {29'd0, busy, done, error}, 32'b010);
    chk("hunt_ww", 32'(words_written), 1);
    idle(2);
    chk("hunt_wr_cnt", 32'(wr_cnt - wr_base), 1);

    // Bad checksum: write still happens, then error.
    wr_base = wr_cnt;
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF});
    chk("bad_w0", {15'd0, mem_we, mem_addr}, 32'h0001_0000);
    chk("bad_d0", 32'(mem_data), 32'hBEEF);
    send_byte(8'h00);
    chk("bad_flags", {29'd0, busy, done, error}, 32'b001);
    chk("bad_ww", 32'(words_written), 1);

    // Length 0x0401 = 1025 > 1024.
    send_byte(8'hA5);
    chk("len_err_clr", 32'(error), 0);
    send_bytes('{8'h04, 8'h01});
    chk("len_flags", {29'd0, busy, done, error}, 32'b001);
    idle(4);
    chk("len_wr_cnt", 32'(wr_cnt - wr_base), 1);

    // Timeout after one written word.
    wr_base = wr_cnt;
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
    chk("tmo_w0", {15'd0, mem_we, mem_addr}, 32'h0001_0000);
    idle(50);
    chk("tmo_pending", {30'd0, busy, error}, 32'b10);
    idle(TMO);
    chk("tmo_flags", {29'd0, busy, done, error}, 32'b001);
    chk("tmo_ww", 32'(words_written), 1);
    chk("tmo_wr_cnt", 32'(wr_cnt - wr_base), 1);
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
    chk("empty_flags", {29'd0, busy, done, error}, 32'b010);
    chk("empty_ww", 32'(words_written), 0);

    // load_en drops in the very cycle that would accept the low data byte.
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12});
    wr_base = wr_cnt;
    @(negedge sysclk);
    @(negedge sysclk);
    byte_in    = 8'h34;
    byte_valid = 1'b1;
    load_en    = 1'b0;
    @(negedge sysclk);
    byte_valid = 1'b0;
    chk("drop_we", 32'(mem_we), 0);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_state", 32'(dut.state_q), 32'(IDLE));
    idle(4);
    chk("drop_wr_cnt", 32'(wr_cnt - wr_base), 0);
    chk("drop_flags", {29'd0, busy, done, error}, 0);
    load_en = 1'b1;
    idle(3);

    // Asynchronous reset mid-frame.
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
    chk("rst2_pre", 32'(mem_data), 32'h1234);
    @(negedge sysclk);
    sysrst = 1'b0;
    #1;
    chk("rst2_data", 32'(mem_data), 0);
    chk("rst2_flags", {28'd0, mem_we, busy, done, error}, 0);
    chk("rst2_ww", 32'(words_written), 0);
    chk("rst2_state", 32'(dut.state_q), 32'(IDLE));
    idle(2);
    sysrst = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
